sm83_regfile_port: RTL and testbench
====================================

# sm83_regfile_port

Debug-side accessor for the SM83 register file. It dumps the full architectural register state as a 14-byte stream, or restores that state from a 14-byte stream, by driving the register file's read selects and write strobes. It sits between the debug/save-state transport and the register file. While it is busy, the core top muxes the register-file write ports to this block, and the core is held halted.

## Interface
Parameters: none. Types come from `sm83_pkg`.

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`
- cmd_op  in  1  0 = dump, 1 = load; sampled at the command handshake
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse
- tx_data  out  8  dump byte
- tx_valid  out  1  dump byte valid
- tx_ready  in  1  sink ready
- rx_data  in  8  load byte
- rx_valid  in  1  load byte valid
- rx_ready  out  1  block ready for a load byte
- rf_r_ir, rf_r_ie, rf_r_a, rf_r_f, rf_r8_gp  in  8  register-file read ports
- rf_r_sp, rf_r_pc  in  16  register-file read ports
- rf_r_sel8_gp  out  gp_r8_sel_t  8-bit GP read select
- rf_wen  out  reg_wen_vec_t  write strobes; only ir, ie, a, f, gp8, sp, pc are ever set, gp16 is always 0
- rf_w_sel8_gp  out  gp_r8_sel_t  8-bit GP write select
- rf_wdata8  out  8  shared data for w_ir, w_ie, w_a, w_f, w8_gp
- rf_wdata16  out  16  shared data for w_sp, w_pc

## Operation
- Stream order, byte index 0..13: IR, IE, A, F, B, C, D, E, H, L, SP[15:8], SP[7:0], PC[15:8], PC[7:0].
- States: IDLE, DUMP, LOAD. A 4-bit index `idx` runs 0..13.
- IDLE
  - `cmd_ready=1`.
  - On the command handshake: `idx<=0`, then go to DUMP (cmd_op=0) or LOAD (cmd_op=1).
- DUMP
  - `tx_valid=1`.
  - `tx_data` is a combinational mux of the read ports selected by `idx`.
  - `rf_r_sel8_gp` is B/C/D/E/H/L for idx 4..9, and REG_B otherwise.
  - On a tx handshake: `idx<=idx+1`.
  - On the handshake at idx 13: go to IDLE and pulse `done`.
- LOAD
  - `rx_ready=1`.
  - Bytes at idx 10 and 12 are held in `hi_hold` and produce no write.
  - Every other byte produces exactly one registered write strobe in the cycle after its handshake:
    - idx 0..3 write IR, IE, A, F.
    - idx 4..9 write gp8 with the matching select.
    - idx 11 writes SP = {hi_hold, rx_data}.
    - idx 13 writes PC = {hi_hold, rx_data}.
  - F is written as {rx_data[7:4], 4'h0}.
  - The handshake at idx 13 moves the state to IDLE. `done` pulses in the same cycle as the PC write strobe.
- `rx_valid` is ignored outside LOAD, `tx_ready` is ignored outside DUMP, and `cmd_valid` is ignored while busy.
- `busy=1` from the cycle after the command handshake through the `done` cycle inclusive.
- Reset (synchronous, at any point) has this effect:
  - State goes to IDLE; `idx`, `hi_hold`, the write strobes and the data registers are cleared.
  - A pending strobe is dropped and no `done` pulse is issued.
  - Registers already written keep their new values.

## Timing
- Outputs in the cycle after a reset edge:
  - cmd_ready=1.
  - busy, done, tx_valid, rx_ready = 0; rf_wen=0.
  - rf_wdata8=0, rf_wdata16=0; rf_r_sel8_gp=REG_B, rf_w_sel8_gp=REG_B.
  - tx_data=0.
- Command handshake at cycle T:
  - busy=1 and tx_valid or rx_ready = 1 from T+1.
  - `cmd_ready=0` from T+1.
- Dump with `tx_ready` held high: 14 cycles (T+1..T+14), `done` at T+14, `cmd_ready=1` at T+15.
- Load with `rx_valid` held high: 14 handshakes (T+1..T+14), last strobe and `done` at T+15.
- Back-pressure:
  - In DUMP, `tx_data` and `tx_valid` stay stable until `tx_ready`.
  - In LOAD, stalls on `rx_valid` insert no strobes.
- Consecutive load bytes give back-to-back single-cycle strobes, never two in the same cycle.
- The register file's read ports are combinational. DUMP values therefore reflect register-file contents in the cycle they are presented; the core must not write the register file while `busy`.

## Test plan
- Preload A=12, F=B0, B..L=01..06, SP=FFFE, PC=0150; dump with tx_ready=1 → tx bytes ..,12,B0,01,02,03,04,05,06,FF,FE,01,50 at T+1..T+14, done at T+14.
- Load the stream 00,1F,AA,FF,11,22,33,44,55,66,C0,00,01,00 → then dump returns the same bytes except byte 3 = F0; SP=C000, PC=0100; rf_wen.gp16 never set.
- Dump with tx_ready toggling 1/0 each cycle → 14 unique bytes, each held stable while stalled, done at T+27.
- Load with rx_valid low for 3 cycles after byte 10 (SP hi) → no strobe during the gap; SP written once with the correct value.
- Assert rst after 6 load bytes → busy=0, no done; IR..C hold the new values, D..PC unchanged; the next dump succeeds.
- cmd_valid held high through an operation → exactly one operation per handshake; a second command is accepted at the first cycle after `done`.

Source files
------------

// File: rtl/sm83_regfile_port.sv
// sm83_regfile_port: debug-side accessor that dumps the SM83 architectural
// register state as a 14-byte stream or restores it from one.
// Stream order: IR, IE, A, F, B, C, D, E, H, L, SPH, SPL, PCH, PCL.

package sm83_pkg;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5
    } gp_r8_sel_t;

    typedef struct packed {
        logic ir;
        logic ie;
        logic a;
        logic f;
        logic gp8;
        logic gp16;
        logic sp;
        logic pc;
    } reg_wen_vec_t;

endpackage

module sm83_regfile_port
    import sm83_pkg::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    output logic         busy,
    output logic         done,

    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,

    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,

    input  logic [7:0]   rf_r_ir,
    input  logic [7:0]   rf_r_ie,
    input  logic [7:0]   rf_r_a,
    input  logic [7:0]   rf_r_f,
    input  logic [7:0]   rf_r8_gp,
    input  logic [15:0]  rf_r_sp,
    input  logic [15:0]  rf_r_pc,
    output gp_r8_sel_t   rf_r_sel8_gp,

    output reg_wen_vec_t rf_wen,
    output gp_r8_sel_t   rf_w_sel8_gp,
    output logic [7:0]   rf_wdata8,
    output logic [15:0]  rf_wdata16
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  idx_q;
    logic [7:0]  hi_hold_q;
    logic        load_done_q;
    logic        cmd_fire;
    logic        tx_fire;
    logic        rx_fire;

    // Stream index 4..9 maps onto the 8-bit GP registers B..L.
    function automatic gp_r8_sel_t gp_sel(input logic [3:0] i);
        case (i)
            4'd5:    return REG_C;
            4'd6:    return REG_D;
            4'd7:    return REG_E;
            4'd8:    return REG_H;
            4'd9:    return REG_L;
            default: return REG_B;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshakes and status outputs.
    // The load completion is registered so done lines up with the PC strobe;
    // busy stays high through that trailing cycle after the FSM is back in IDLE.
    always_comb begin
        state_d   = state_q;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        cmd_fire  = 1'b0;
        tx_fire   = 1'b0;
        rx_fire   = 1'b0;
        done      = load_done_q;
        busy      = (state_q != S_IDLE) || load_done_q;
        cmd_ready = !busy;
        case (state_q)
            S_IDLE: begin
                cmd_fire = cmd_valid && !load_done_q;
                if (cmd_fire) begin
                    state_d = cmd_op ? S_LOAD : S_DUMP;
                end
            end
            S_DUMP: begin
                tx_valid = 1'b1;
                tx_fire  = tx_ready;
                if (tx_ready && (idx_q == 4'd13)) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            S_LOAD: begin
                rx_ready = 1'b1;
                rx_fire  = rx_valid;
                if (rx_valid && (idx_q == 4'd13)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dump path: combinational byte mux over the register-file read ports
    always_comb begin
        tx_data      = '0;
        rf_r_sel8_gp = REG_B;
        if (state_q == S_DUMP) begin
            rf_r_sel8_gp = gp_sel(idx_q);
            case (idx_q)
                4'd0:    tx_data = rf_r_ir;
                4'd1:    tx_data = rf_r_ie;
                4'd2:    tx_data = rf_r_a;
                4'd3:    tx_data = rf_r_f;
                4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                         tx_data = rf_r8_gp;
                4'd10:   tx_data = rf_r_sp[15:8];
                4'd11:   tx_data = rf_r_sp[7:0];
                4'd12:   tx_data = rf_r_pc[15:8];
                4'd13:   tx_data = rf_r_pc[7:0];
                default: tx_data = '0;
            endcase
        end
    end

    // Index, high-byte hold and registered single-cycle write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            hi_hold_q    <= '0;
            rf_wen       <= '0;
            rf_w_sel8_gp <= REG_B;
            rf_wdata8    <= '0;
            rf_wdata16   <= '0;
            load_done_q  <= 1'b0;
        end else begin
            rf_wen      <= '0;
            load_done_q <= 1'b0;
            if (cmd_fire) begin
                idx_q <= '0;
            end
            if (tx_fire) begin
                idx_q <= idx_q + 4'd1;
            end
            if (rx_fire) begin
                idx_q <= idx_q + 4'd1;
                case (idx_q)
                    4'd0: begin
                        rf_wen.ir <= 1'b1;
                        rf_wdata8 <= rx_data;
                    end
                    4'd1: begin
                        rf_wen.ie <= 1'b1;
                        rf_wdata8 <= rx_data;
                    end
                    4'd2: begin
                        rf_wen.a  <= 1'b1;
                        rf_wdata8 <= rx_data;
                    end
                    4'd3: begin
                        rf_wen.f  <= 1'b1;
                        rf_wdata8 <= {rx_data[7:4], 4'h0};
                    end
                    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                        rf_wen.gp8   <= 1'b1;
                        rf_w_sel8_gp <= gp_sel(idx_q);
                        rf_wdata8    <= rx_data;
                    end
                    4'd10, 4'd12: begin
                        hi_hold_q <= rx_data;
                    end
                    4'd11: begin
                        rf_wen.sp  <= 1'b1;
                        rf_wdata16 <= {hi_hold_q, rx_data};
                    end
                    4'd13: begin
                        rf_wen.pc   <= 1'b1;
                        rf_wdata16  <= {hi_hold_q, rx_data};
                        load_done_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm83_regfile_port.sv
// Testbench for sm83_regfile_port: a behavioural register file around the
// accessor, with scoreboards for dump bytes and load write strobes.

module tb_sm83_regfile_port;
    import sm83_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_op = 1'b0;
    logic         busy;
    logic         done;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [7:0]   rf_r_ir, rf_r_ie, rf_r_a, rf_r_f, rf_r8_gp;
    logic [15:0]  rf_r_sp, rf_r_pc;
    gp_r8_sel_t   rf_r_sel8_gp;
    reg_wen_vec_t rf_wen;
    gp_r8_sel_t   rf_w_sel8_gp;
    logic [7:0]   rf_wdata8;
    logic [15:0]  rf_wdata16;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q [$];
    logic [7:0]  wq_wen [$];
    logic [2:0]  wq_sel [$];
    logic [15:0] wq_data [$];
    logic [7:0]  exp_state [14];

    // behavioural register file (stream order 0..9 for the 8-bit registers)
    logic [7:0]  rf8 [0:9];
    logic [15:0] rf_sp, rf_pc;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_bytes [14];
    int          sp_cnt = 0;
    int          gp16_cnt = 0;

    always #5 clk = ~clk;

    sm83_regfile_port dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .busy         (busy),
        .done         (done),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rf_r_ir      (rf_r_ir),
        .rf_r_ie      (rf_r_ie),
        .rf_r_a       (rf_r_a),
        .rf_r_f       (rf_r_f),
        .rf_r8_gp     (rf_r8_gp),
        .rf_r_sp      (rf_r_sp),
        .rf_r_pc      (rf_r_pc),
        .rf_r_sel8_gp (rf_r_sel8_gp),
        .rf_wen       (rf_wen),
        .rf_w_sel8_gp (rf_w_sel8_gp),
        .rf_wdata8    (rf_wdata8),
        .rf_wdata16   (rf_wdata16)
    );

    assign rf_r_ir  = rf8[0];
    assign rf_r_ie  = rf8[1];
    assign rf_r_a   = rf8[2];
    assign rf_r_f   = rf8[3];
    assign rf_r8_gp = rf8[4'd4 + {1'b0, rf_r_sel8_gp}];
    assign rf_r_sp  = rf_sp;
    assign rf_r_pc  = rf_pc;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 10; i++) rf8[i] <= pre_bytes[i];
            rf_sp <= {pre_bytes[10], pre_bytes[11]};
            rf_pc <= {pre_bytes[12], pre_bytes[13]};
        end else begin
            if (rf_wen.ir)  rf8[0] <= rf_wdata8;
            if (rf_wen.ie)  rf8[1] <= rf_wdata8;
            if (rf_wen.a)   rf8[2] <= rf_wdata8;
            if (rf_wen.f)   rf8[3] <= rf_wdata8;
            if (rf_wen.gp8) rf8[4'd4 + {1'b0, rf_w_sel8_gp}] <= rf_wdata8;
            if (rf_wen.sp)  rf_sp <= rf_wdata16;
            if (rf_wen.pc)  rf_pc <= rf_wdata16;
        end
        if (rf_wen.sp)   sp_cnt <= sp_cnt + 1;
        if (rf_wen.gp16) gp16_cnt <= gp16_cnt + 1;
    end

    task automatic preload(input logic [7:0] b [14]);
        pre_bytes = b;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        exp_state = b;
    endtask

    task automatic start_cmd(input logic op);
        cmd_valid = 1'b1;
        cmd_op = op;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || (tx_valid | rx_ready) !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: busy=%b cmd_ready=%b tx_valid=%b rx_ready=%b want 1,0,active",
                     busy, cmd_ready, tx_valid, rx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0 ||
            rx_ready !== 1'b0 || rf_wen !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: cmd_ready=%b busy=%b done=%b tx_valid=%b rx_ready=%b wen=%h want 1,0,0,0,0,00",
                     cmd_ready, busy, done, tx_valid, rx_ready, rf_wen);
        end
        checks++;
        if (rf_wdata8 !== 8'h00 || rf_wdata16 !== 16'h0000 || tx_data !== 8'h00 ||
            rf_r_sel8_gp !== REG_B || rf_w_sel8_gp !== REG_B) begin
            errors++;
            $display("FAIL reset_data: wd8=%h wd16=%h tx=%h rsel=%0d wsel=%0d want 00,0000,00,0,0",
                     rf_wdata8, rf_wdata16, tx_data, rf_r_sel8_gp, rf_w_sel8_gp);
        end
    endtask

    // mode 0: tx_ready held high; mode 1: tx_ready high on odd cycles only
    task automatic test_dump(input int mode, input int exp_done);
        int c;
        int got;
        for (int i = 0; i < 14; i++) exp_q.push_back(exp_state[i]);
        start_cmd(1'b0);
        c = 1;
        got = 0;
        while (got < 14 && c < 80) begin
            tx_ready = (mode == 0) ? 1'b1 : ((c % 2) == 1);
            #1;
            checks++;
            if (tx_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL dump_valid: cycle %0d tx_valid=%b busy=%b want 1,1", c, tx_valid, busy);
            end
            checks++;
            if (tx_data !== exp_q[0]) begin
                errors++;
                $display("FAIL dump_byte: byte %0d cycle %0d got %h want %h", got, c, tx_data, exp_q[0]);
            end
            if (tx_ready) begin
                void'(exp_q.pop_front());
                got++;
                checks++;
                if (done !== (got == 14)) begin
                    errors++;
                    $display("FAIL dump_done: cycle %0d got %b want %b", c, done, (got == 14));
                end
                if (got == 14) begin
                    checks++;
                    if (c != exp_done) begin
                        errors++;
                        $display("FAIL dump_done_cycle: got T+%0d want T+%0d", c, exp_done);
                    end
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL dump_stall_done: cycle %0d got %b want 0", c, done);
                end
            end
            @(negedge clk);
            c++;
        end
        tx_ready = 1'b0;
        if (got < 14) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: got %0d bytes want 14", got);
            exp_q.delete();
        end
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_end: cmd_ready=%b busy=%b want 1,0", cmd_ready, busy);
        end
    endtask

    task automatic test_load(input logic [7:0] b [14], input int gap_after, input int gap_len);
        int c;
        int k;
        int gap_left;
        int finished;
        int sp0;
        int g0;
        logic [7:0]  ow;
        logic [2:0]  osel;
        logic [7:0]  ew;
        logic [2:0]  es;
        logic [15:0] ed;
        sp0 = sp_cnt;
        g0 = gp16_cnt;
        start_cmd(1'b1);
        c = 1;
        k = 0;
        gap_left = 0;
        finished = 0;
        while (finished == 0 && c < 80) begin
            ow = rf_wen;
            osel = rf_w_sel8_gp;
            if (ow != 8'h00) begin
                checks++;
                if (wq_wen.size() == 0) begin
                    errors++;
                    $display("FAIL load_strobe_unexpected: cycle %0d wen=%h want 00", c, ow);
                end else begin
                    ew = wq_wen.pop_front();
                    es = wq_sel.pop_front();
                    ed = wq_data.pop_front();
                    if (ow !== ew || (ew == 8'h08 && osel !== es) ||
                        ((ew[1] | ew[0]) ? (rf_wdata16 !== ed) : (rf_wdata8 !== ed[7:0]))) begin
                        errors++;
                        $display("FAIL load_strobe: cycle %0d wen=%h sel=%0d wd8=%h wd16=%h want wen=%h sel=%0d data=%h",
                                 c, ow, osel, rf_wdata8, rf_wdata16, ew, es, ed);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (c != 15 + gap_len || ow !== 8'h01 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL load_done: cycle T+%0d wen=%h busy=%b want T+%0d,01,1",
                             c, ow, busy, 15 + gap_len);
                end
                finished = 1;
            end
            if (finished == 0 && k < 14 && gap_left == 0) begin
                rx_valid = 1'b1;
                rx_data = b[k];
                #1;
                checks++;
                if (rx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL load_ready: byte %0d got %b want 1", k, rx_ready);
                end
                case (k)
                    0, 1, 2: begin
                        wq_wen.push_back(8'h80 >> k); wq_sel.push_back(3'd0); wq_data.push_back({8'h00, b[k]});
                    end
                    3: begin
                        wq_wen.push_back(8'h10); wq_sel.push_back(3'd0); wq_data.push_back({8'h00, b[k][7:4], 4'h0});
                    end
                    4, 5, 6, 7, 8, 9: begin
                        wq_wen.push_back(8'h08); wq_sel.push_back(3'(k - 4)); wq_data.push_back({8'h00, b[k]});
                    end
                    11: begin
                        wq_wen.push_back(8'h02); wq_sel.push_back(3'd0); wq_data.push_back({b[10], b[11]});
                    end
                    13: begin
                        wq_wen.push_back(8'h01); wq_sel.push_back(3'd0); wq_data.push_back({b[12], b[13]});
                    end
                    default: begin
                    end
                endcase
                if (k == gap_after) gap_left = gap_len;
                k++;
            end else begin
                rx_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            @(negedge clk);
            c++;
        end
        rx_valid = 1'b0;
        if (finished == 0) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: no done within %0d cycles", c);
        end
        checks++;
        if (wq_wen.size() != 0) begin
            errors++;
            $display("FAIL load_missing_strobes: got %0d left want 0", wq_wen.size());
            wq_wen.delete(); wq_sel.delete(); wq_data.delete();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_end: busy=%b cmd_ready=%b want 0,1", busy, cmd_ready);
        end
        checks++;
        if (sp_cnt - sp0 != 1 || gp16_cnt != g0) begin
            errors++;
            $display("FAIL load_counts: sp writes=%0d gp16 writes=%0d want 1,0", sp_cnt - sp0, gp16_cnt - g0);
        end
        exp_state = b;
        exp_state[3] = {b[3][7:4], 4'h0};
    endtask

    task automatic test_reset_mid_load(input logic [7:0] b [14]);
        start_cmd(1'b1);
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data = b[i];
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_done_early: byte %0d got %b want 0", i, done);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rf_wen !== 8'h00 || cmd_ready !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b wen=%h cmd_ready=%b rx_ready=%b want 0,0,00,1,0",
                     busy, done, rf_wen, cmd_ready, rx_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || rf_wen !== 8'h00) begin
                errors++;
                $display("FAIL abort_quiet: cycle %0d done=%b wen=%h want 0,00", i, done, rf_wen);
            end
        end
        for (int i = 0; i < 6; i++) exp_state[i] = b[i];
        exp_state[3] = {b[3][7:4], 4'h0};
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 14; i++) exp_q.push_back(exp_state[i]);
        cmd_valid = 1'b1;
        cmd_op = 1'b0;
        tx_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        for (int c = 1; c <= 29; c++) begin
            #1;
            checks++;
            if (cmd_ready !== (c == 15) || done !== (c == 14 || c == 29)) begin
                errors++;
                $display("FAIL b2b_timing: cycle %0d cmd_ready=%b done=%b want %b,%b",
                         c, cmd_ready, done, (c == 15), (c == 14 || c == 29));
            end
            if (done === 1'b1) dones++;
            if (tx_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || tx_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_byte: cycle %0d got %h want %h", c, tx_data,
                             (exp_q.size() == 0) ? 8'hxx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(negedge clk);
            if (c == 15) cmd_valid = 1'b0;
        end
        tx_ready = 1'b0;
        #1;
        checks++;
        if (dones != 2 || exp_q.size() != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: dones=%0d left=%0d busy=%b cmd_ready=%b want 2,0,0,1",
                     dones, exp_q.size(), busy, cmd_ready);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [7:0] pre_s [14];
        logic [7:0] ld1 [14];
        logic [7:0] ld2 [14];
        logic [7:0] ld3 [14];
        pre_s = '{8'h3C, 8'h09, 8'h12, 8'hB0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'hFE, 8'h01, 8'h50};
        ld1   = '{8'h00, 8'h1F, 8'hAA, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hC0, 8'h00, 8'h01, 8'h00};
        ld2   = '{8'h7E, 8'hE1, 8'h5A, 8'hA7, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34, 8'h56, 8'h78};
        ld3   = '{8'h81, 8'h82, 8'h83, 8'h8F, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D};

        test_reset();
        preload(pre_s);
        test_dump(0, 14);
        test_load(ld1, -1, 0);
        test_dump(0, 14);
        test_dump(1, 27);
        test_load(ld2, 10, 3);
        test_dump(0, 14);
        test_reset_mid_load(ld3);
        test_dump(0, 14);
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
